// File: rtl/cursor_ctrl_pkg.sv
// Shared definitions for the cursor controller and the board logic that
// consumes its commands.
//   OP_REVEAL / OP_FLAG : cmd_op encodings
//   buf_state_t         : command buffer occupancy states
package cursor_ctrl_pkg;

   localparam logic OP_REVEAL = 1'b0;
   localparam logic OP_FLAG   = 1'b1;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_TWO   = 2'd2
   } buf_state_t;

endpackage

// File: rtl/cursor_ctrl_wrap_counter.sv
// Wrapping up/down position counter for one cursor axis.
//   clk, rst  : clock, async active-low reset (value -> 0)
//   inc, dec  : step requests; both together cancel out
//   value     : current position, range 0..MAX, wraps at both ends
module wrap_counter #(
   parameter  int MAX = 7,
   localparam int W   = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] value
);

   localparam logic [W-1:0] TOP = W'(MAX);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         value <= '0;
      end else if (inc && !dec) begin
         value <= (value == TOP) ? '0 : value + W'(1);
      end else if (dec && !inc) begin
         value <= (value == '0) ? TOP : value - W'(1);
      end
   end

endmodule

// File: rtl/cursor_ctrl.sv
// Cursor controller: moves a cursor over a GRID_W x GRID_H board from button
// pulses and turns select/flag pulses into commands for the board logic,
// buffered in a 2-entry queue (output register + one pending register).
//   clk, rst                      : clock, async active-low reset
//   btn_up/down/left/right        : one-cycle move pulses
//   btn_sel, btn_flag             : one-cycle reveal / flag-toggle requests
//   game_active                   : low blocks all button pulses
//   cur_x, cur_y                  : cursor position
//   cmd_valid/op/x/y, cmd_ready   : command handshake to the board logic
//   cmd_drop                      : one-cycle pulse when a request is discarded
//
// Command buffer states:
//   state     | meaning
//   BUF_EMPTY | no command held, cmd_valid low
//   BUF_ONE   | output register holds a command
//   BUF_TWO   | output register and pending register both hold commands
module cursor_ctrl
   import cursor_ctrl_pkg::*;
#(
   parameter  int GRID_W = 8,
   parameter  int GRID_H = 8,
   localparam int XW     = $clog2(GRID_W),
   localparam int YW     = $clog2(GRID_H)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          btn_up,
   input  logic          btn_down,
   input  logic          btn_left,
   input  logic          btn_right,
   input  logic          btn_sel,
   input  logic          btn_flag,
   input  logic          game_active,
   output logic [XW-1:0] cur_x,
   output logic [YW-1:0] cur_y,
   output logic          cmd_valid,
   output logic          cmd_op,
   output logic [XW-1:0] cmd_x,
   output logic [YW-1:0] cmd_y,
   input  logic          cmd_ready,
   output logic          cmd_drop
);

   buf_state_t    state, nxt_state;
   logic          out_op, nxt_out_op;
   logic [XW-1:0] out_x, nxt_out_x;
   logic [YW-1:0] out_y, nxt_out_y;
   logic          pend_op, nxt_pend_op;
   logic [XW-1:0] pend_x, nxt_pend_x;
   logic [YW-1:0] pend_y, nxt_pend_y;
   logic          drop_q, nxt_drop;

   logic          req_valid;
   logic          req_op;
   logic          op_clash;
   logic          hs;

   wrap_counter #(.MAX(GRID_W - 1)) u_wrap_x (
      .clk   (clk),
      .rst   (rst),
      .inc   (game_active & btn_right),
      .dec   (game_active & btn_left),
      .value (cur_x)
   );

   wrap_counter #(.MAX(GRID_H - 1)) u_wrap_y (
      .clk   (clk),
      .rst   (rst),
      .inc   (game_active & btn_down),
      .dec   (game_active & btn_up),
      .value (cur_y)
   );

   // Requests sample cur_x/cur_y as registered, i.e. before any same-cycle move.
   assign req_valid = game_active & (btn_sel | btn_flag);
   assign req_op    = btn_sel ? OP_REVEAL : OP_FLAG;
   assign op_clash  = game_active & btn_sel & btn_flag;
   assign hs        = cmd_valid & cmd_ready;

   always_comb begin
      nxt_state   = state;
      nxt_out_op  = out_op;
      nxt_out_x   = out_x;
      nxt_out_y   = out_y;
      nxt_pend_op = pend_op;
      nxt_pend_x  = pend_x;
      nxt_pend_y  = pend_y;
      nxt_drop    = op_clash;

      case (state)
         BUF_EMPTY: begin
            if (req_valid) begin
               nxt_state  = BUF_ONE;
               nxt_out_op = req_op;
               nxt_out_x  = cur_x;
               nxt_out_y  = cur_y;
            end
         end
         BUF_ONE: begin
            if (hs && req_valid) begin
               nxt_out_op = req_op;
               nxt_out_x  = cur_x;
               nxt_out_y  = cur_y;
            end else if (hs) begin
               nxt_state = BUF_EMPTY;
            end else if (req_valid) begin
               nxt_state   = BUF_TWO;
               nxt_pend_op = req_op;
               nxt_pend_x  = cur_x;
               nxt_pend_y  = cur_y;
            end
         end
         BUF_TWO: begin
            if (hs) begin
               nxt_out_op = pend_op;
               nxt_out_x  = pend_x;
               nxt_out_y  = pend_y;
               if (req_valid) begin
                  nxt_pend_op = req_op;
                  nxt_pend_x  = cur_x;
                  nxt_pend_y  = cur_y;
               end else begin
                  nxt_state = BUF_ONE;
               end
            end else if (req_valid) begin
               nxt_drop = 1'b1;
            end
         end
         default: begin
            nxt_state = BUF_EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= BUF_EMPTY;
         out_op  <= OP_REVEAL;
         out_x   <= '0;
         out_y   <= '0;
         pend_op <= OP_REVEAL;
         pend_x  <= '0;
         pend_y  <= '0;
         drop_q  <= 1'b0;
      end else begin
         state   <= nxt_state;
         out_op  <= nxt_out_op;
         out_x   <= nxt_out_x;
         out_y   <= nxt_out_y;
         pend_op <= nxt_pend_op;
         pend_x  <= nxt_pend_x;
         pend_y  <= nxt_pend_y;
         drop_q  <= nxt_drop;
      end
   end

   assign cmd_valid = (state != BUF_EMPTY);
   assign cmd_op    = out_op;
   assign cmd_x     = out_x;
   assign cmd_y     = out_y;
   assign cmd_drop  = drop_q;

endmodule

// File: tb/tb_cursor_ctrl.sv
module tb_cursor_ctrl;

   localparam int GW = 8;
   localparam int GH = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
   logic       btn_sel = 1'b0, btn_flag = 1'b0;
   logic       game_active = 1'b0;
   logic       cmd_ready = 1'b0;
   logic [2:0] cur_x, cur_y, cmd_x, cmd_y;
   logic       cmd_valid, cmd_op, cmd_drop;

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit op;
      int x;
      int y;
   } cmd_t;

   int   mx = 0, my = 0;
   bit   mdrop = 0;
   cmd_t mq[$];

   cursor_ctrl #(.GRID_W(GW), .GRID_H(GH)) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_up      (btn_up),
      .btn_down    (btn_down),
      .btn_left    (btn_left),
      .btn_right   (btn_right),
      .btn_sel     (btn_sel),
      .btn_flag    (btn_flag),
      .game_active (game_active),
      .cur_x       (cur_x),
      .cur_y       (cur_y),
      .cmd_valid   (cmd_valid),
      .cmd_op      (cmd_op),
      .cmd_x       (cmd_x),
      .cmd_y       (cmd_y),
      .cmd_ready   (cmd_ready),
      .cmd_drop    (cmd_drop)
   );

   always #5 clk = ~clk;

   // Reference model: cursor positions modulo grid size, command buffer as a
   // queue holding at most two entries.
   task automatic model_step();
      int   rx, ry;
      cmd_t c;
      rx    = mx;
      ry    = my;
      mdrop = 0;
      if (mq.size() > 0 && cmd_ready) void'(mq.pop_front());
      if (game_active) begin
         mx = (mx + int'(btn_right) - int'(btn_left) + GW) % GW;
         my = (my + int'(btn_down) - int'(btn_up) + GH) % GH;
         if (btn_sel || btn_flag) begin
            if (btn_sel && btn_flag) mdrop = 1;
            c.op = btn_sel ? 1'b0 : 1'b1;
            c.x  = rx;
            c.y  = ry;
            if (mq.size() < 2) mq.push_back(c);
            else mdrop = 1;
         end
      end
   endtask

   task automatic model_reset();
      mx = 0;
      my = 0;
      mdrop = 0;
      mq.delete();
   endtask

   // One clock: update model with current inputs, advance to just after the
   // edge, then clear the one-cycle button pulses.
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
      btn_sel = 0; btn_flag = 0;
   endtask

   task automatic goto(input int tx, input int ty);
      for (int i = 0; i < 40 && (mx != tx || my != ty); i++) begin
         btn_right = (mx != tx);
         btn_down  = (my != ty);
         cycle();
      end
   endtask

   task automatic test_reset();
      rst = 0;
      #12;
      checks++;
      if ({cur_x, cur_y, cmd_valid, cmd_op, cmd_x, cmd_y, cmd_drop} !== 15'd0) begin
         errors++;
         $display("FAIL reset_state: got x=%0d y=%0d v=%0b op=%0b cx=%0d cy=%0d drop=%0b, want all 0",
                  cur_x, cur_y, cmd_valid, cmd_op, cmd_x, cmd_y, cmd_drop);
      end
      @(negedge clk);
      rst = 1;
      game_active = 1;
      model_reset();
      @(posedge clk);
      #1;
   endtask

   task automatic test_left_wrap();
      int exp_x[3] = '{7, 6, 5};
      for (int i = 0; i < 3; i++) begin
         btn_left = 1;
         cycle();
         checks++;
         if (cur_x !== 3'(exp_x[i]) || cur_y !== 3'd0) begin
            errors++;
            $display("FAIL left_wrap_%0d: got (%0d,%0d), want (%0d,0)", i, cur_x, cur_y, exp_x[i]);
         end
      end
   endtask

   task automatic test_diagonal();
      btn_up = 1;
      btn_right = 1;
      cycle();
      checks++;
      if (cur_x !== 3'd6 || cur_y !== 3'd7) begin
         errors++;
         $display("FAIL diagonal: got (%0d,%0d), want (6,7)", cur_x, cur_y);
      end
      btn_left = 1;
      btn_right = 1;
      cycle();
      checks++;
      if (cur_x !== 3'd6 || cur_y !== 3'd7) begin
         errors++;
         $display("FAIL left_right_cancel: got (%0d,%0d), want (6,7)", cur_x, cur_y);
      end
   endtask

   task automatic test_buffer();
      cmd_ready = 0;
      goto(2, 3);
      btn_sel = 1;
      cycle();
      checks++;
      if ({cmd_valid, cmd_op, cmd_x, cmd_y} !== {1'b1, 1'b0, 3'd2, 3'd3}) begin
         errors++;
         $display("FAIL buf_first: got v=%0b op=%0b (%0d,%0d), want v=1 op=0 (2,3)",
                  cmd_valid, cmd_op, cmd_x, cmd_y);
      end
      goto(4, 4);
      btn_flag = 1;
      cycle();
      checks++;
      if ({cmd_valid, cmd_op, cmd_x, cmd_y, cmd_drop} !== {1'b1, 1'b0, 3'd2, 3'd3, 1'b0}) begin
         errors++;
         $display("FAIL buf_hold: got v=%0b op=%0b (%0d,%0d) drop=%0b, want v=1 op=0 (2,3) drop=0",
                  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_drop);
      end
      btn_sel = 1;
      cycle();
      checks++;
      if (cmd_drop !== 1'b1) begin
         errors++;
         $display("FAIL buf_full_drop: got drop=%0b, want 1", cmd_drop);
      end
      cycle();
      checks++;
      if (cmd_drop !== 1'b0) begin
         errors++;
         $display("FAIL buf_drop_pulse: got drop=%0b, want 0", cmd_drop);
      end
      cmd_ready = 1;
      cycle();
      checks++;
      if ({cmd_valid, cmd_op, cmd_x, cmd_y} !== {1'b1, 1'b1, 3'd4, 3'd4}) begin
         errors++;
         $display("FAIL buf_second: got v=%0b op=%0b (%0d,%0d), want v=1 op=1 (4,4)",
                  cmd_valid, cmd_op, cmd_x, cmd_y);
      end
      cycle();
      checks++;
      if (cmd_valid !== 1'b0) begin
         errors++;
         $display("FAIL buf_drained: got v=%0b, want 0", cmd_valid);
      end
      cmd_ready = 0;
   endtask

   task automatic test_both_ops();
      btn_sel = 1;
      btn_flag = 1;
      cycle();
      checks++;
      if ({cmd_valid, cmd_op, cmd_drop} !== 3'b101 || cmd_x !== 3'(mq[0].x)) begin
         errors++;
         $display("FAIL sel_flag_clash: got v=%0b op=%0b drop=%0b x=%0d, want v=1 op=0 drop=1 x=%0d",
                  cmd_valid, cmd_op, cmd_drop, cmd_x, mq[0].x);
      end
      cmd_ready = 1;
      cycle();
      checks++;
      if ({cmd_valid, cmd_drop} !== 2'b00) begin
         errors++;
         $display("FAIL sel_flag_single: got v=%0b drop=%0b, want v=0 drop=0", cmd_valid, cmd_drop);
      end
      cmd_ready = 0;
   endtask

   task automatic test_inactive();
      logic [2:0] sx, sy;
      sx = 3'(mx);
      sy = 3'(my);
      btn_flag = 1;
      cycle();
      game_active = 0;
      for (int i = 0; i < 4; i++) begin
         btn_up = 1; btn_right = 1; btn_sel = 1;
         cycle();
         checks++;
         if (cur_x !== sx || cur_y !== sy || cmd_valid !== 1'b1 || cmd_op !== 1'b1 ||
             cmd_x !== sx || cmd_y !== sy || cmd_drop !== 1'b0) begin
            errors++;
            $display("FAIL inactive_%0d: got cur=(%0d,%0d) v=%0b op=%0b cmd=(%0d,%0d) drop=%0b, want cur=(%0d,%0d) v=1 op=1 cmd=(%0d,%0d) drop=0",
                     i, cur_x, cur_y, cmd_valid, cmd_op, cmd_x, cmd_y, cmd_drop, sx, sy, sx, sy);
         end
      end
      cmd_ready = 1;
      cycle();
      checks++;
      if (cmd_valid !== 1'b0) begin
         errors++;
         $display("FAIL inactive_drain: got v=%0b, want 0", cmd_valid);
      end
      cmd_ready = 0;
      game_active = 1;
   endtask

   task automatic test_async_reset();
      goto(3, 5);
      btn_sel = 1;
      cycle();
      btn_flag = 1;
      cycle();
      checks++;
      if (cmd_valid !== 1'b1 || mq.size() != 2) begin
         errors++;
         $display("FAIL ar_fill: got v=%0b, want 1 with two buffered", cmd_valid);
      end
      cmd_ready = 1;
      #2;
      rst = 0;
      #1;
      checks++;
      if ({cur_x, cur_y, cmd_valid, cmd_op, cmd_x, cmd_y, cmd_drop} !== 15'd0) begin
         errors++;
         $display("FAIL async_reset: got x=%0d y=%0d v=%0b op=%0b cx=%0d cy=%0d drop=%0b, want all 0",
                  cur_x, cur_y, cmd_valid, cmd_op, cmd_x, cmd_y, cmd_drop);
      end
      cmd_ready = 0;
      model_reset();
      @(negedge clk);
      rst = 1;
      @(posedge clk);
      #1;
      btn_sel = 1;
      cycle();
      checks++;
      if ({cmd_valid, cmd_op, cmd_x, cmd_y} !== {1'b1, 1'b0, 3'd0, 3'd0}) begin
         errors++;
         $display("FAIL ar_first_req: got v=%0b op=%0b (%0d,%0d), want v=1 op=0 (0,0)",
                  cmd_valid, cmd_op, cmd_x, cmd_y);
      end
      cmd_ready = 1;
      cycle();
      checks++;
      if (cmd_valid !== 1'b0) begin
         errors++;
         $display("FAIL ar_no_stale: got v=%0b, want 0", cmd_valid);
      end
      cmd_ready = 0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         btn_up      = ($urandom_range(0, 3) == 0);
         btn_down    = ($urandom_range(0, 3) == 0);
         btn_left    = ($urandom_range(0, 3) == 0);
         btn_right   = ($urandom_range(0, 3) == 0);
         btn_sel     = ($urandom_range(0, 2) == 0);
         btn_flag    = ($urandom_range(0, 2) == 0);
         game_active = ($urandom_range(0, 7) != 0);
         cmd_ready   = ($urandom_range(0, 2) == 0);
         cycle();
         checks++;
         if (cur_x !== 3'(mx) || cur_y !== 3'(my) || cmd_drop !== mdrop ||
             cmd_valid !== (mq.size() > 0)) begin
            errors++;
            $display("FAIL rand_%0d: got cur=(%0d,%0d) v=%0b drop=%0b, want cur=(%0d,%0d) v=%0b drop=%0b",
                     n, cur_x, cur_y, cmd_valid, cmd_drop, mx, my, mq.size() > 0, mdrop);
         end else if (mq.size() > 0) begin
            checks++;
            if (cmd_op !== mq[0].op || cmd_x !== 3'(mq[0].x) || cmd_y !== 3'(mq[0].y)) begin
               errors++;
               $display("FAIL rand_cmd_%0d: got op=%0b (%0d,%0d), want op=%0b (%0d,%0d)",
                        n, cmd_op, cmd_x, cmd_y, mq[0].op, mq[0].x, mq[0].y);
            end
         end
      end
      game_active = 1;
      cmd_ready = 0;
   endtask

   initial begin
      test_reset();
      test_left_wrap();
      test_diagonal();
      test_buffer();
      test_both_ops();
      test_inactive();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
